// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue/sequencing controller and its decoders.
package alu_ctrl_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned OP_COUNT = 14;

   // R-type funct codes (valid only when opcode == 0)
   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_SLA  = 6'h01;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_SRA  = 6'h03;
   localparam logic [5:0] FUNCT_MUL  = 6'h18;
   localparam logic [5:0] FUNCT_DIV  = 6'h1A;
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_XOR  = 6'h26;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;

   // Bit positions of the one-hot ALU operation lines
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADDU = 4'd1,
      OP_SUB  = 4'd2,
      OP_SUBU = 4'd3,
      OP_MUL  = 4'd4,
      OP_DIV  = 4'd5,
      OP_AND  = 4'd6,
      OP_OR   = 4'd7,
      OP_XOR  = 4'd8,
      OP_NOR  = 4'd9,
      OP_SRL  = 4'd10,
      OP_SLL  = 4'd11,
      OP_SRA  = 4'd12,
      OP_SLA  = 4'd13
   } op_idx_e;

   // Issue sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_EXEC  = 2'd2,
      ST_WB    = 2'd3
   } state_e;

endpackage

// File: rtl/alu_funct_decoder.sv
// Combinational (opcode, funct) -> one-hot ALU op plus class flags.
module alu_funct_decoder
   import alu_ctrl_pkg::*;
(
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   output logic [OP_COUNT-1:0] op,
   output logic                illegal,
   output logic                is_mul,
   output logic                is_div
);

   // Map funct to its op line; anything unmapped or non-R-type is illegal
   always_comb begin
      op      = '0;
      illegal = 1'b0;
      if (opcode != 6'd0) begin
         illegal = 1'b1;
      end else begin
         case (funct)
            FUNCT_ADD:  op[OP_ADD]  = 1'b1;
            FUNCT_ADDU: op[OP_ADDU] = 1'b1;
            FUNCT_SUB:  op[OP_SUB]  = 1'b1;
            FUNCT_SUBU: op[OP_SUBU] = 1'b1;
            FUNCT_MUL:  op[OP_MUL]  = 1'b1;
            FUNCT_DIV:  op[OP_DIV]  = 1'b1;
            FUNCT_AND:  op[OP_AND]  = 1'b1;
            FUNCT_OR:   op[OP_OR]   = 1'b1;
            FUNCT_XOR:  op[OP_XOR]  = 1'b1;
            FUNCT_NOR:  op[OP_NOR]  = 1'b1;
            FUNCT_SRL:  op[OP_SRL]  = 1'b1;
            FUNCT_SLL:  op[OP_SLL]  = 1'b1;
            FUNCT_SRA:  op[OP_SRA]  = 1'b1;
            FUNCT_SLA:  op[OP_SLA]  = 1'b1;
            default:    illegal     = 1'b1;
         endcase
      end
      is_mul = op[OP_MUL];
      is_div = op[OP_DIV];
   end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue/sequencing controller: accepts an R-type op, drives the one-hot ALU
// for an op-dependent number of enable cycles, and returns the result.
module alu_issue_seq
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned LAT_BASIC = 1,
   parameter int unsigned LAT_MUL   = 2,
   parameter int unsigned LAT_DIV   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [31:0]         in_rs,
   input  logic [31:0]         in_rt,
   output logic [31:0]         alu_a,
   output logic [31:0]         alu_b,
   output logic [31:0]         alu_c,
   output logic [OP_COUNT-1:0] alu_op,
   output logic                alu_enable,
   input  logic [31:0]         alu_result,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [4:0]          wb_rd,
   output logic [31:0]         wb_data,
   output logic                wb_err
);

   localparam int unsigned LAT_MAX_MB = (LAT_MUL > LAT_BASIC) ? LAT_MUL : LAT_BASIC;
   localparam int unsigned LAT_MAX    = (LAT_DIV > LAT_MAX_MB) ? LAT_DIV : LAT_MAX_MB;
   localparam int unsigned CNT_W      = $clog2(LAT_MAX) + 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, lat_m1;
   logic                err_q, err_d, mul_q, mul_d, div_q, div_d;
   logic [4:0]          rd_q, rd_d;
   logic                in_ready_d, alu_enable_d, wb_valid_d, wb_err_d;
   logic [31:0]         alu_a_d, alu_b_d, alu_c_d, wb_data_d;
   logic [OP_COUNT-1:0] alu_op_d;
   logic [4:0]          wb_rd_d;

   logic [OP_COUNT-1:0] dec_op;
   logic                dec_illegal, dec_mul, dec_div;
   logic                unused_fields;

   // rs/rt register-number fields are already resolved upstream
   assign unused_fields = ^in_instr[25:16];

   alu_funct_decoder u_dec (
      .opcode  (in_instr[31:26]),
      .funct   (in_instr[5:0]),
      .op      (dec_op),
      .illegal (dec_illegal),
      .is_mul  (dec_mul),
      .is_div  (dec_div)
   );

   // Enable-cycle count minus one for the latched op class
   always_comb begin
      lat_m1 = CNT_W'(LAT_BASIC - 1);
      if (div_q)      lat_m1 = CNT_W'(LAT_DIV - 1);
      else if (mul_q) lat_m1 = CNT_W'(LAT_MUL - 1);
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      mul_d        = mul_q;
      div_d        = div_q;
      rd_d         = rd_q;
      alu_a_d      = alu_a;
      alu_b_d      = alu_b;
      alu_c_d      = alu_c;
      alu_op_d     = alu_op;
      alu_enable_d = 1'b0;
      wb_valid_d   = wb_valid;
      wb_rd_d      = wb_rd;
      wb_data_d    = wb_data;
      wb_err_d     = wb_err;

      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               state_d = ST_SETUP;
               alu_a_d = in_rs;
               alu_b_d = in_rt;
               alu_c_d = 32'(in_instr[10:6]);
               rd_d    = in_instr[15:11];
               mul_d   = dec_mul;
               div_d   = dec_div;
               err_d   = dec_illegal || (dec_div && (in_rt == 32'd0));
               alu_op_d = (dec_illegal || (dec_div && (in_rt == 32'd0))) ? '0 : dec_op;
            end
         end
         ST_SETUP: begin
            if (err_q) begin
               state_d    = ST_WB;
               alu_op_d   = '0;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = 32'd0;
               wb_err_d   = 1'b1;
            end else begin
               state_d      = ST_EXEC;
               alu_enable_d = 1'b1;
               cnt_d        = lat_m1;
            end
         end
         ST_EXEC: begin
            if (cnt_q == CNT_W'(0)) begin
               state_d    = ST_WB;
               alu_op_d   = '0;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = alu_result;
               wb_err_d   = 1'b0;
            end else begin
               alu_enable_d = 1'b1;
               cnt_d        = cnt_q - CNT_W'(1);
            end
         end
         ST_WB: begin
            if (wb_ready) begin
               state_d    = ST_IDLE;
               wb_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d = (state_d == ST_IDLE);
   end

   // State and registered-output update; reset aborts any in-flight op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         mul_q      <= 1'b0;
         div_q      <= 1'b0;
         rd_q       <= '0;
         in_ready   <= 1'b1;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_c      <= '0;
         alu_op     <= '0;
         alu_enable <= 1'b0;
         wb_valid   <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         wb_err     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         mul_q      <= mul_d;
         div_q      <= div_d;
         rd_q       <= rd_d;
         in_ready   <= in_ready_d;
         alu_a      <= alu_a_d;
         alu_b      <= alu_b_d;
         alu_c      <= alu_c_d;
         alu_op     <= alu_op_d;
         alu_enable <= alu_enable_d;
         wb_valid   <= wb_valid_d;
         wb_rd      <= wb_rd_d;
         wb_data    <= wb_data_d;
         wb_err     <= wb_err_d;
      end
   end

endmodule
